// File: rtl/regfile_pkg.sv
// Shared constants, counter type and address-unpacking helper for the
// register file / scoreboard slice.
package regfile_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int NREGS_DEF  = 32;
    localparam int PW_DEF     = 2;
    localparam int ZERO_REG   = 0;
    localparam int ADDR_MAX_W = 64;

    // Pending-write counter at the default width.
    typedef logic [PW_DEF-1:0] pend_t;

    // Extract the aw-bit address of read port k from a packed address bus.
    function automatic logic [ADDR_MAX_W-1:0] port_addr(
        input logic [ADDR_MAX_W-1:0] pk,
        input int                    k,
        input int                    aw
    );
        logic [ADDR_MAX_W-1:0] mask;
        mask = (ADDR_MAX_W'(1) << aw) - ADDR_MAX_W'(1);
        return (pk >> (k * aw)) & mask;
    endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Decode/writeback side bundle of the register file with scoreboard.
interface regfile_sb_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5,
    parameter int NRD  = 2
);
    logic                WR_EN;
    logic [AW-1:0]       WR_ADDR;
    logic [XLEN-1:0]     WR_DATA;
    logic [NRD*AW-1:0]   RD_ADDR;
    logic [NRD*XLEN-1:0] RD_DATA;
    logic [NRD-1:0]      RD_BUSY;
    logic                ISSUE_EN;
    logic [AW-1:0]       ISSUE_ADDR;
    logic                ISSUE_READY;
    logic                ERR;

    modport master (
        output WR_EN, WR_ADDR, WR_DATA, RD_ADDR, ISSUE_EN, ISSUE_ADDR,
        input  RD_DATA, RD_BUSY, ISSUE_READY, ERR
    );

    modport slave (
        input  WR_EN, WR_ADDR, WR_DATA, RD_ADDR, ISSUE_EN, ISSUE_ADDR,
        output RD_DATA, RD_BUSY, ISSUE_READY, ERR
    );
endinterface

// File: rtl/regfile_pend_ctr.sv
// Per-register pending-write counter. The caller only raises inc when the
// reservation is accepted, so a full counter never sees inc without dec.
module regfile_pend_ctr #(
    parameter int PW = 2
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          inc_i,
    input  logic          dec_i,
    output logic [PW-1:0] cnt_o,
    output logic          full_o,
    output logic          underflow_o
);
    logic [PW-1:0] cnt_q, cnt_d;

    // Next count: issue-only increments, writeback-only decrements (saturating at 0).
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !dec_i)
            cnt_d = cnt_q + PW'(1);
        else if (dec_i && !inc_i && cnt_q != '0)
            cnt_d = cnt_q - PW'(1);
    end

    // Counter register with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt_o       = cnt_q;
    assign full_o      = (cnt_q == '1);
    assign underflow_o = dec_i && !inc_i && (cnt_q == '0);
endmodule

// File: rtl/regfile_sb.sv
// Integer register file with NRD combinational read ports, one write port,
// optional writeback bypass and a per-register pending-write scoreboard.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int NRD    = 2,
    parameter int PW     = PW_DEF,
    parameter bit BYPASS = 1'b1
) (
    input logic          CLK,
    input logic          RESET,
    regfile_sb_if.slave  bus
);
    localparam int AW = $clog2(NREGS);
    localparam logic [AW-1:0] X0 = AW'(ZERO_REG);

    logic [XLEN-1:0] mem_q [NREGS];
    logic [PW-1:0]   cnt   [NREGS];
    logic [NREGS-1:0] full, uflow, inc, dec;
    logic            err_q, err_d;
    logic            wr_live;

    assign wr_live = bus.WR_EN && (bus.WR_ADDR != X0);

    // A same-cycle writeback to the reserved register frees a slot.
    assign bus.ISSUE_READY = (bus.ISSUE_ADDR == X0) || !full[bus.ISSUE_ADDR] ||
                             (wr_live && (bus.WR_ADDR == bus.ISSUE_ADDR));

    // x0 has no counter; tie its slot so shared index logic stays simple.
    assign cnt[0]   = '0;
    assign full[0]  = 1'b0;
    assign uflow[0] = 1'b0;
    assign inc[0]   = 1'b0;
    assign dec[0]   = 1'b0;

    for (genvar r = 1; r < NREGS; r++) begin : g_ctr
        assign inc[r] = bus.ISSUE_EN && bus.ISSUE_READY && (bus.ISSUE_ADDR == AW'(r));
        assign dec[r] = bus.WR_EN && (bus.WR_ADDR == AW'(r));
        regfile_pend_ctr #(.PW(PW)) u_ctr (
            .CLK         (CLK),
            .RESET       (RESET),
            .inc_i       (inc[r]),
            .dec_i       (dec[r]),
            .cnt_o       (cnt[r]),
            .full_o      (full[r]),
            .underflow_o (uflow[r])
        );
    end

    // Register storage; writes to x0 are dropped so it reads as zero forever.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
        end else if (wr_live) begin
            mem_q[bus.WR_ADDR] <= bus.WR_DATA;
        end
    end

    // Any writeback that finds nothing pending latches the error.
    always_comb err_d = err_q || (|uflow);

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge CLK) begin
        if (RESET) err_q <= 1'b0;
        else       err_q <= err_d;
    end

    assign bus.ERR = err_q;

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] a;
        logic          hit;
        assign a   = AW'(port_addr(ADDR_MAX_W'(bus.RD_ADDR), k, AW));
        assign hit = BYPASS && wr_live && (bus.WR_ADDR == a);
        assign bus.RD_DATA[k*XLEN +: XLEN] = (a == X0) ? '0 :
                                             hit       ? bus.WR_DATA : mem_q[a];
        // Busy unless the last outstanding write is landing right now.
        assign bus.RD_BUSY[k] = (a != X0) && (cnt[a] > PW'(hit));
    end
endmodule
